muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Multi-cycle integer multiply/divide unit in the execute stage of the pipelined MIPS core.
- Takes its operands from the register-file read ports (after forwarding muxes) and owns the architectural HI/LO registers.
- Drives `busy` so the hazard unit can stall dependent instructions; MFHI/MFLO read `hi`/`lo` and write them back to the register file.
- Iterative radix-2 datapath: 33-cycle latency for MULT/MULTU/DIV/DIVU; MTHI/MTLO complete in one cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (only 32 is verified).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation this cycle; accepted only when `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are NOP.
- `a`  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b`  in  32  rt operand (multiplier / divisor).
- `cancel`  in  1  pipeline flush; aborts an in-flight operation.
- `busy`  out  1  long operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a long-op result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, SIGN. A 5-bit step counter is used in CALC.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops use the operands as-is.
  - Latch the result-sign flags: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the counter and go to CALC.
- IDLE, `start`=1, op MTHI/MTLO: `hi`/`lo` ← `a` at that edge. State stays IDLE; `busy` and `done` stay 0.
- IDLE, NOP op: no effect.
- CALC: one iteration per cycle, 32 iterations (counter 0..31).
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and a 32-bit remainder.
  - After iteration 31, go to SIGN.
- SIGN:
  - Negate the result where the sign flags require it.
  - Multiply writes {hi,lo} = 64-bit product.
  - Divide writes lo = quotient, hi = remainder.
  - Pulse `done`, return to IDLE.
- Divide by zero (b=0), signed or unsigned: lo=32'hFFFFFFFF, hi=a (original, unmodified dividend). Still takes the full 33 cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of 32-bit wrap in the magnitude datapath.
- All arithmetic is modulo 2^32 per register; the product is exact in 64 bits.
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The hazard unit must hold the instruction.
- `cancel`:
  - In CALC or SIGN: return to IDLE at the next edge. `hi`/`lo` keep their pre-operation values; no `done`.
  - In IDLE: `cancel` overrides `start` (no write, no launch).
- Reset (async, any state, including mid-operation):
  - State IDLE, counter 0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- Let E0 be the edge at which `start` is accepted.
- `busy`:
  - Goes to 1 after E0.
  - Is 1 for exactly 33 cycles (32 CALC + 1 SIGN).
  - Falls after E33.
- `hi`/`lo` take the result at E33; `done`=1 for the single cycle after E33.
- A new `start` can be accepted at E33's following edge (E34). Back-to-back issue has 34-edge spacing.
- MTHI/MTLO: register updated at E0 and visible on `hi`/`lo` the cycle after E0.
- `hi`/`lo` are driven straight from the registers: no combinational path from `a`/`b`/`op` to any output.
- `busy` is a registered state decode, so the hazard unit can use it in the same cycle without loops.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=7 -> `busy` high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` pulse 1 cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 one cycle after each. Repeat while `busy`=1 -> hi/lo unchanged.
- Preload hi=0xAAAA, lo=0xBBBB; start DIVU; assert `cancel` on the 10th busy cycle -> `busy`=0 next cycle, no `done`, hi=0xAAAA, lo=0xBBBB. Then `start`+`cancel` together in IDLE -> nothing launched.
- Start MULT and drop `reset_n` mid-CALC between clock edges -> `busy`, `done`, `hi`, `lo` go to 0 without waiting for an edge. After release, a fresh MULTU 3×5 gives lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Long operations take 33 cycles (32 iterations plus a sign-fixup cycle); MTHI/MTLO complete in one.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]     opd_reg, opd_next;
    logic [WIDTH-1:0]     a_orig_reg, a_orig_next;
    logic                 is_div_reg, is_div_next;
    logic                 neg_q_reg, neg_q_next;
    logic                 neg_r_reg, neg_r_next;
    logic                 dbz_reg, dbz_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;
    logic                 done_reg, done_next;

    // Operand magnitudes: signed ops (op[0]=0) take the two's-complement absolute value.
    logic             signed_op;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign signed_op = ~op[0];
    assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditionally add the multiplicand to the upper half, then shift right.
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = opd_reg[gi] & acc_reg[0];
        end
    endgenerate
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: acc holds {remainder, dividend/quotient}.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_step;
    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opd_reg};
    assign div_step  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed, rem_signed;
    assign prod_signed = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_signed  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_signed  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opd_next    = opd_reg;
        a_orig_next = a_orig_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        dbz_next    = dbz_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        is_div_next = op[1];
                        neg_q_next  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_next  = signed_op & a[WIDTH-1];
                        dbz_next    = op[1] && (b == '0);
                        a_orig_next = a;
                        // Multiply keeps the multiplier in acc and multiplicand in opd; divide the reverse roles.
                        acc_next    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                        opd_next    = op[1] ? b_abs : a_abs;
                        cnt_next    = '0;
                        state_next  = CALC;
                    end else if (op[1:0] == 2'b00) begin
                        hi_next = a;
                    end else if (op[1:0] == 2'b01) begin
                        lo_next = a;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    acc_next = is_div_reg ? div_step : mul_step;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next = SIGN;
                    end
                end
            end
            SIGN: begin
                state_next = IDLE;
                if (!cancel) begin
                    done_next = 1'b1;
                    if (!is_div_reg) begin
                        {hi_next, lo_next} = prod_signed;
                    end else if (dbz_reg) begin
                        lo_next = '1;
                        hi_next = a_orig_reg;
                    end else begin
                        lo_next = quo_signed;
                        hi_next = rem_signed;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opd_reg    <= '0;
            a_orig_reg <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dbz_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opd_reg    <= opd_next;
            a_orig_reg <= a_orig_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            dbz_reg    <= dbz_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: long ops, MTHI/MTLO, busy blocking, cancel and async reset.
module tb_muldiv_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge; returns just after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        int n = 0;
        int early_done = 0;
        int guard = 0;
        issue(o, av, bv);
        while (busy && guard < 100) begin
            n++;
            if (done) early_done++;
            tick();
            guard++;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_early_done"}, 64'(early_done), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        $display("txn %s op=%b a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, o, av, bv, hi, lo, n);
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        cancel  = 1'b0;
        op      = 3'b111;
        a       = '0;
        b       = '0;
        #2;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        #10 reset_n = 1'b1;
        tick();

        run_long("mult_neg3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_long("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_long("mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_long("div_neg7by2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_long("divu_by0",     OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        run_long("div_neg_by0",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        run_long("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // MTHI then MTLO on consecutive edges.
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        tick();
        op = OP_MTLO; a = 32'h5678;
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h5678);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        check("mtlo_done", {63'd0, done}, 64'd0);
        $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

        // MTHI/MTLO while busy must be ignored; the divide result lands normally.
        begin
            int guard = 0;
            issue(OP_DIVU, 32'd100, 32'd7);
            issue(OP_MTHI, 32'hDEAD, 32'd0);
            check("busy_mthi_hi", {32'd0, hi}, 64'h1234);
            issue(OP_MTLO, 32'hBEEF, 32'd0);
            check("busy_mtlo_lo", {32'd0, lo}, 64'h5678);
            while (busy && guard < 100) begin
                tick();
                guard++;
            end
            check("busy_div_hi", {32'd0, hi}, 64'd2);
            check("busy_div_lo", {32'd0, lo}, 64'd14);
            $display("txn divu-under-mt hi=%h lo=%h", hi, lo);
            tick();
        end

        // Cancel on the 10th busy cycle.
        issue(OP_MTHI, 32'hAAAA, 32'd0);
        issue(OP_MTLO, 32'hBBBB, 32'd0);
        begin
            int seen = 0;
            issue(OP_DIVU, 32'd1000, 32'd3);
            for (int i = 0; i < 9; i++) tick();
            check("cancel_still_busy", {63'd0, busy}, 64'd1);
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            check("cancel_busy", {63'd0, busy}, 64'd0);
            check("cancel_done", {63'd0, done}, 64'd0);
            check("cancel_hi", {32'd0, hi}, 64'hAAAA);
            check("cancel_lo", {32'd0, lo}, 64'hBBBB);
            for (int i = 0; i < 40; i++) begin
                if (done || busy) seen++;
                tick();
            end
            check("cancel_no_late_done", 64'(seen), 64'd0);
            $display("txn divu-cancel hi=%h lo=%h", hi, lo);
        end

        // start+cancel together in IDLE: nothing happens.
        cancel = 1'b1;
        issue(OP_MTHI, 32'h1111, 32'd0);
        check("idle_cancel_mthi", {32'd0, hi}, 64'hAAAA);
        issue(OP_MULT, 32'd2, 32'd3);
        cancel = 1'b0;
        check("idle_cancel_mult", {63'd0, busy}, 64'd0);
        $display("txn idle-cancel busy=%b hi=%h", busy, hi);

        // Asynchronous reset mid-CALC, applied between edges.
        issue(OP_MULT, 32'd5, 32'd6);
        for (int i = 0; i < 4; i++) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_busy", {63'd0, busy}, 64'd0);
        check("areset_done", {63'd0, done}, 64'd0);
        check("areset_hi", {32'd0, hi}, 64'd0);
        check("areset_lo", {32'd0, lo}, 64'd0);
        $display("txn async-reset busy=%b hi=%h lo=%h", busy, hi, lo);
        #10 reset_n = 1'b1;
        tick();
        run_long("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
